// File: rtl/host_packet_deframer.sv
// host_packet_deframer: hunts START_ID in a first-word-fall-through byte FIFO,
// assembles a big-endian 4-byte header, an optional address word and data
// words, and presents each result to the host master with an ih_ready pulse.
// Optional build macro HOST_DEFRAMER_TIMEOUT_EN: aborts a packet that stalls
// in HEADER, ADDRESS or DATA for TIMEOUT_CYCLES cycles and pulses timeout.
module host_packet_deframer #(
  parameter int         DATA_BYTES     = 4,
  parameter int         COUNT_WIDTH    = 24,
  parameter logic [7:0] START_ID       = 8'hCD,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      byte_empty,
  input  logic [7:0]                byte_data,
  output logic                      byte_rd,
  input  logic                      master_ready,
  output logic                      ih_ready,
  output logic                      ih_reset,
  output logic [31:0]               in_command,
  output logic [31:0]               in_address,
  output logic [8*DATA_BYTES-1:0]   in_data,
  output logic [COUNT_WIDTH-1:0]    in_data_count,
  output logic                      proto_err,
  output logic                      timeout,
  output logic                      busy
);

  localparam int                     DW             = 8 * DATA_BYTES;
  localparam logic [2:0]             LAST_DATA_BYTE = 3'(DATA_BYTES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE      = COUNT_WIDTH'(1);

  localparam logic [3:0] CMD_PING  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_READ  = 4'd2;
  localparam logic [3:0] CMD_RESET = 4'd3;

  typedef enum logic [2:0] {IDLE, HEADER, DECODE, ADDRESS, DATA, NOTIFY} state_t;

  state_t                 state;
  logic [2:0]             byte_cnt;    // bytes already collected in the current word
  logic [31:0]            word_sr;     // header / address assembly
  logic [DW-1:0]          data_sr;     // data word assembly
  logic [3:0]             flags;
  logic [3:0]             cmd;
  logic [COUNT_WIDTH-1:0] count_rem;   // data words not yet delivered
  logic                   pop;
  logic                   stall_hit;
  logic [31:0]            word_next;
  logic [DW-1:0]          data_next;

  // NOTE: byte_rd is combinational so the head byte is consumed on the same
  // edge that captures it; a registered pop would read every byte twice.
  assign pop = rst_n && !byte_empty &&
               (state == IDLE || state == HEADER || state == ADDRESS || state == DATA);
  assign byte_rd = pop;

  // Big-endian assembly: each new byte enters at the LSB, earlier bytes move up.
  assign word_next = {word_sr[23:0], byte_data};
  assign data_next = (data_sr << 8) | DW'(byte_data);

  assign busy = (state != IDLE);

`ifdef HOST_DEFRAMER_TIMEOUT_EN
  logic [19:0] stall_cnt;
  logic        stalled;

  assign stalled   = byte_empty && (state == HEADER || state == ADDRESS || state == DATA);
  assign stall_hit = stalled && (stall_cnt == 20'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts empty cycles in byte-collecting states; any pop or
  // state change breaks the stall and restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!stalled || stall_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 20'd1;
    end
  end
`else
  // Never true: without the stall counter the FSM waits indefinitely. The
  // parameter is still referenced so both builds share one parameter list.
  assign stall_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      word_sr       <= '0;
      data_sr       <= '0;
      flags         <= '0;
      cmd           <= '0;
      count_rem     <= '0;
      in_command    <= '0;
      in_address    <= '0;
      in_data       <= '0;
      in_data_count <= '0;
      ih_ready      <= 1'b0;
      ih_reset      <= 1'b0;
      proto_err     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a later assignment in this
      // block overrides, which keeps each pulse exactly one cycle wide.
      ih_ready  <= 1'b0;
      ih_reset  <= 1'b0;
      proto_err <= 1'b0;
      timeout   <= 1'b0;

      if (stall_hit) begin
        timeout  <= 1'b1;
        state    <= IDLE;
        byte_cnt <= '0;
        word_sr  <= '0;
        data_sr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            byte_cnt <= '0;
            if (pop && byte_data == START_ID) state <= HEADER;
          end

          HEADER: if (pop) begin
            word_sr <= word_next;
            if (byte_cnt == 3'd3) begin
              byte_cnt  <= '0;
              flags     <= word_next[31:28];
              cmd       <= word_next[27:24];
              count_rem <= word_next[COUNT_WIDTH-1:0];
              state     <= DECODE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end

          DECODE: begin
            case (cmd)
              CMD_PING: begin
                in_command <= {12'h0, flags, 12'h0, cmd};
                state      <= NOTIFY;
              end
              CMD_WRITE: begin
                if (count_rem == '0) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
                end else begin
                  in_command <= {12'h0, flags, 12'h0, cmd};
                  state      <= ADDRESS;
                end
              end
              CMD_READ: begin
                in_command <= {12'h0, flags, 12'h0, cmd};
                state      <= ADDRESS;
              end
              CMD_RESET: begin
                ih_reset <= 1'b1;
                state    <= IDLE;
              end
              default: begin
                proto_err <= 1'b1;
                state     <= IDLE;
              end
            endcase
          end

          ADDRESS: if (pop) begin
            word_sr <= word_next;
            if (byte_cnt == 3'd3) begin
              byte_cnt   <= '0;
              in_address <= word_next;
              state      <= (cmd == CMD_WRITE) ? DATA : NOTIFY;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end

          DATA: if (pop) begin
            data_sr <= data_next;
            if (byte_cnt == LAST_DATA_BYTE) begin
              byte_cnt      <= '0;
              in_data       <= data_next;
              in_data_count <= count_rem - COUNT_ONE;
              count_rem     <= count_rem - COUNT_ONE;
              state         <= NOTIFY;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end

          NOTIFY: if (master_ready) begin
            ih_ready <= 1'b1;
            state    <= (cmd == CMD_WRITE && in_data_count != '0) ? DATA : IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_packet_deframer.sv
// Testbench for host_packet_deframer: directed scenarios plus randomized
// packet streams checked against a packet-level reference model.
module tb_host_packet_deframer;

  localparam int         DATA_BYTES  = 4;
  localparam int         COUNT_WIDTH = 24;
  localparam int         DW          = 8 * DATA_BYTES;
  localparam int         TO_CYCLES   = 16;
  localparam logic [7:0] SID         = 8'hCD;

  typedef enum logic [1:0] {EV_READY, EV_RESET, EV_ERR, EV_TO} ev_kind_t;
  typedef struct packed {
    ev_kind_t               kind;
    logic [31:0]            cmd;
    logic [31:0]            addr;
    logic [DW-1:0]          data;
    logic [COUNT_WIDTH-1:0] cnt;
  } ev_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   byte_empty;
  logic [7:0]             byte_data;
  logic                   byte_rd;
  logic                   master_ready;
  logic                   ih_ready, ih_reset, proto_err, timeout, busy;
  logic [31:0]            in_command, in_address;
  logic [DW-1:0]          in_data;
  logic [COUNT_WIDTH-1:0] in_data_count;

  int tests = 0;
  int fails = 0;

  host_packet_deframer #(
    .DATA_BYTES(DATA_BYTES), .COUNT_WIDTH(COUNT_WIDTH),
    .START_ID(SID), .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_empty(byte_empty), .byte_data(byte_data),
    .byte_rd(byte_rd), .master_ready(master_ready), .ih_ready(ih_ready),
    .ih_reset(ih_reset), .in_command(in_command), .in_address(in_address),
    .in_data(in_data), .in_data_count(in_data_count), .proto_err(proto_err),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- FWFT byte FIFO model ----------------
  logic [7:0] stream_mem [0:4095];
  int wr_lim = 0;
  int rd_ptr = 0;

  assign byte_empty = (rd_ptr >= wr_lim);
  assign byte_data  = byte_empty ? 8'h00 : stream_mem[rd_ptr % 4096];

  always begin : fifo_pop
    logic take;
    @(negedge clk);
    take = byte_rd && !byte_empty;
    @(posedge clk);
    #1;
    if (take) rd_ptr = rd_ptr + 1;
  end

  // ---------------- master_ready driver ----------------
  logic ready_random = 1'b0;
  logic ready_force  = 1'b1;

  always begin : ready_drv
    @(posedge clk);
    #1;
    master_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- output monitor ----------------
  ev_t obs_mem [0:1023];
  int  obs_cnt   = 0;
  int  bad_pulse = 0;
  int  bad_rd    = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_rd && byte_empty) bad_rd++;
      if ($countones({ih_ready, ih_reset, proto_err, timeout}) > 1) bad_pulse++;
      if (ih_ready | ih_reset | proto_err | timeout) begin
        ev_t o;
        o.kind = ih_ready ? EV_READY : ih_reset ? EV_RESET : proto_err ? EV_ERR : EV_TO;
        o.cmd  = in_command;
        o.addr = in_address;
        o.data = in_data;
        o.cnt  = in_data_count;
        obs_mem[obs_cnt % 1024] = o;
        obs_cnt++;
      end
    end
  end

  // ---------------- packet-level reference model ----------------
  ev_t                    exp_q[$];
  logic [7:0]             pkt[$];
  logic [31:0]            wq[$];
  int                     obs_rd = 0;
  logic [31:0]            m_addr = '0;
  logic [DW-1:0]          m_data = '0;
  logic [COUNT_WIDTH-1:0] m_cnt  = '0;

  function automatic ev_t mk(input ev_kind_t k, input logic [31:0] c);
    ev_t e;
    e.kind = k; e.cmd = c; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    return e;
  endfunction

  task automatic put32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) pkt.push_back(w[8*i +: 8]);
  endtask

  task automatic add_garbage(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == SID) b = 8'h00;
      pkt.push_back(b);
    end
  endtask

  task automatic add_cmd(input logic [3:0] flags, input logic [3:0] cmd, input logic [23:0] count);
    pkt.push_back(SID);
    put32({flags, cmd, count});
  endtask

  task automatic add_ping(input logic [3:0] flags);
    add_cmd(flags, 4'h0, 24'($urandom));
    exp_q.push_back(mk(EV_READY, {12'h0, flags, 12'h0, 4'h0}));
  endtask

  task automatic add_read(input logic [3:0] flags, input logic [31:0] addr);
    add_cmd(flags, 4'h2, 24'($urandom));
    put32(addr);
    m_addr = addr;
    exp_q.push_back(mk(EV_READY, {12'h0, flags, 12'h0, 4'h2}));
  endtask

  // Data words come from wq; one ready event per word, remaining count descending.
  task automatic add_write(input logic [3:0] flags, input logic [31:0] addr);
    int n;
    n = wq.size();
    add_cmd(flags, 4'h1, 24'(n));
    put32(addr);
    m_addr = addr;
    for (int i = 0; i < n; i++) begin
      put32(wq[i]);
      m_data = wq[i];
      m_cnt  = COUNT_WIDTH'(n - 1 - i);
      exp_q.push_back(mk(EV_READY, {12'h0, flags, 12'h0, 4'h1}));
    end
    wq.delete();
  endtask

  task automatic send(input bit burst);
    while (pkt.size() > 0) begin
      stream_mem[wr_lim % 4096] = pkt.pop_front();
      wr_lim = wr_lim + 1;
      if (!burst && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic expect_events(input string tag, input int budget);
    int n;
    int waited;
    n = exp_q.size();
    waited = 0;
    while ((obs_cnt - obs_rd) < n && waited < budget) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check({tag, "_event_count"}, 64'(obs_cnt - obs_rd), 64'(n));
    while (exp_q.size() > 0 && obs_rd < obs_cnt) begin
      ev_t e;
      ev_t o;
      e = exp_q.pop_front();
      o = obs_mem[obs_rd % 1024];
      obs_rd++;
      check({tag, "_kind"}, 64'(o.kind), 64'(e.kind));
      if (e.kind == EV_READY) begin
        check({tag, "_command"}, o.cmd, e.cmd);
        check({tag, "_address"}, o.addr, e.addr);
        check({tag, "_data"}, o.data, e.data);
        check({tag, "_count"}, o.cnt, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic wait_drained(input string tag);
    int w;
    w = 0;
    while (rd_ptr != wr_lim && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    check({tag, "_drained"}, 64'(rd_ptr), 64'(wr_lim));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_rd"}, byte_rd, 1'b0);
    check({tag, "_pulses"}, {ih_ready, ih_reset, proto_err, timeout}, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_command"}, in_command, 32'h0);
    check({tag, "_in_address"}, in_address, 32'h0);
    check({tag, "_in_data"}, in_data, '0);
    check({tag, "_in_data_count"}, in_data_count, '0);
  endtask

  // Reset with a non-start byte waiting, so byte_rd must be held low.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stream_mem[wr_lim % 4096] = 8'h3C;
    wr_lim = wr_lim + 1;
    #1;
    check_all_zero(tag);
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int  pops;
    int  rd_mark;
    int  obs_mark;
    int  n;
    logic got;

    rst_n = 1'b0;
    stream_mem[0] = 8'h55;
    wr_lim = 1;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // PING with all-zero header
    add_cmd(4'h0, 4'h0, 24'h0);
    exp_q.push_back(mk(EV_READY, 32'h0));
    send(1'b1);
    expect_events("ping", 200);
    check("ping_in_command", in_command, 32'h0);

    // WRITE of two words preceded by garbage
    pkt.push_back(8'h11);
    pkt.push_back(8'h22);
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    add_write(4'h0, 32'h0000_1000);
    send(1'b1);
    expect_events("write", 300);
    repeat (2) @(negedge clk);
    check("write_busy_drop", busy, 1'b0);

    // Backpressure: master_ready low for 50 cycles while words wait
    @(posedge clk);
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    wq.push_back(32'hCDCD_0001);
    wq.push_back(32'hCD00_CDCD);
    add_write(4'hA, 32'hCD00_00CD);
    send(1'b1);
    repeat (20) @(posedge clk);
    #2;
    rd_mark  = rd_ptr;
    obs_mark = obs_cnt;
    pops     = 0;
    repeat (50) begin
      @(negedge clk);
      if (byte_rd) pops++;
    end
    check("bp_no_pops", 64'(pops), 64'd0);
    check("bp_fifo_held", 64'(rd_ptr), 64'(rd_mark));
    check("bp_no_ready", 64'(obs_cnt), 64'(obs_mark));
    check("bp_busy", busy, 1'b1);
    @(posedge clk);
    ready_force = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", ih_ready, 1'b0);
    @(negedge clk);
    check("bp_ready_next_cycle", ih_ready, 1'b1);
    expect_events("bp", 300);

    // Bad command then PING
    @(posedge clk);
    #2;
    add_cmd(4'h0, 4'h7, 24'h0);
    exp_q.push_back(mk(EV_ERR, 32'h0));
    add_ping(4'h3);
    send(1'b1);
    expect_events("badcmd", 300);

    // WRITE with zero count, RESET command
    add_cmd(4'h2, 4'h1, 24'h0);
    exp_q.push_back(mk(EV_ERR, 32'h0));
    add_cmd(4'h0, 4'h3, 24'h0);
    exp_q.push_back(mk(EV_RESET, 32'h0));
    send(1'b1);
    expect_events("zero_write_reset", 300);

    // Stall after CD,01
    pkt.push_back(SID);
    pkt.push_back(8'h01);
    send(1'b1);
    wait_drained("stall");
`ifdef HOST_DEFRAMER_TIMEOUT_EN
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = timeout;
    end
    check("timeout_latency", 64'(n), 64'(TO_CYCLES));
    exp_q.push_back(mk(EV_TO, 32'h0));
    expect_events("timeout", 10);
    @(negedge clk);
    check("timeout_idle", busy, 1'b0);
    @(posedge clk);
    #2;
`else
    obs_mark = obs_cnt;
    repeat (100) @(negedge clk);
    check("stall_busy_held", busy, 1'b1);
    check("stall_no_event", 64'(obs_cnt), 64'(obs_mark));
    apply_reset("stall_reset");
`endif

    // Reset mid-packet after CD,02,00
    pkt.push_back(SID);
    pkt.push_back(8'h02);
    pkt.push_back(8'h00);
    send(1'b1);
    wait_drained("midpkt");
    apply_reset("midpkt_reset");
    add_cmd(4'h0, 4'h0, 24'h0);
    exp_q.push_back(mk(EV_READY, 32'h0));
    send(1'b1);
    expect_events("after_reset", 300);

    // Randomized packet streams with random backpressure and FIFO gaps
    ready_random = 1'b1;
    for (int b = 0; b < 12; b++) begin
      for (int p = 0; p < 4; p++) begin
        int sel;
        add_garbage($urandom_range(0, 3));
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1: add_ping(4'($urandom));
          2, 3: add_read(4'($urandom), $urandom);
          4, 5, 6: begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            add_write(4'($urandom), $urandom);
          end
          7: begin
            add_cmd(4'($urandom), 4'h3, 24'($urandom));
            exp_q.push_back(mk(EV_RESET, 32'h0));
          end
          8: begin
            add_cmd(4'($urandom), 4'($urandom_range(4, 15)), 24'($urandom));
            exp_q.push_back(mk(EV_ERR, 32'h0));
          end
          default: begin
            add_cmd(4'($urandom), 4'h1, 24'h0);
            exp_q.push_back(mk(EV_ERR, 32'h0));
          end
        endcase
      end
      send(1'b0);
      expect_events("rand", 3000);
    end

    repeat (10) @(posedge clk);
    check("final_no_extra_events", 64'(obs_cnt), 64'(obs_rd));
    check("pulse_exclusive", 64'(bad_pulse), 64'd0);
    check("byte_rd_only_nonempty", 64'(bad_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/host_packet_deframer.md
HOST_PACKET_DEFRAMER -- requirements
Module: host_packet_deframer

Interface
REQ-001 Parameter DATA_BYTES, default 4: data word width in bytes; legal values 1, 2, 4, 8; DW = 8*DATA_BYTES.
REQ-002 Parameter COUNT_WIDTH, default 24: width of the word count; legal range 1..24.
REQ-003 Parameter START_ID, default 8'hCD: packet start byte.
REQ-004 Parameter TIMEOUT_CYCLES, default 65535: stall limit in cycles; legal range 1..2^20-1.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 byte_empty  in  1  byte FIFO empty.
REQ-008 byte_data  in  8  FIFO head byte, first-word-fall-through, valid while !byte_empty.
REQ-009 byte_rd  out  1  pops one byte; asserted only while !byte_empty.
REQ-010 master_ready  in  1  master can accept a command.
REQ-011 ih_ready  out  1  one-cycle pulse: in_* outputs are valid.
REQ-012 ih_reset  out  1  one-cycle pulse: RESET command received.
REQ-013 in_command  out  32  {12'h0, flags[3:0], 12'h0, cmd[3:0]}.
REQ-014 in_address  out  32  address word.
REQ-015 in_data  out  DW  current data word.
REQ-016 in_data_count  out  COUNT_WIDTH  data words remaining after in_data.
REQ-017 proto_err  out  1  one-cycle pulse: bad command or zero-count WRITE.
REQ-018 timeout  out  1  one-cycle pulse: stall abort.
REQ-019 busy  out  1  high whenever state != IDLE.

Function
REQ-020 FSM states: IDLE, HEADER, DECODE, ADDRESS, DATA, NOTIFY.
REQ-021 IDLE pops every byte. A byte equal to START_ID moves the FSM to HEADER. All other bytes are discarded.
REQ-022 In HEADER, ADDRESS and DATA, one byte is popped per cycle while !byte_empty. Bytes assemble big-endian: the first byte goes to the MSB.
REQ-023 HEADER collects 4 bytes: h[31:28]=flags, h[27:24]=cmd, h[COUNT_WIDTH-1:0]=count. Higher count bits are ignored. The FSM then moves to DECODE.
REQ-024 DECODE action by cmd:
- 0 PING: go to NOTIFY.
- 1 WRITE: go to ADDRESS.
- 2 READ: go to ADDRESS.
- 3 RESET: pulse ih_reset, go to IDLE.
- Any other cmd: pulse proto_err, go to IDLE.
- WRITE with count==0: pulse proto_err, go to IDLE.
REQ-025 ADDRESS collects 4 bytes into in_address. READ then goes to NOTIFY. WRITE then goes to DATA.
REQ-026 DATA collects DATA_BYTES bytes into in_data. On the last byte, in_data_count is loaded with the remaining count (count-1 on the first word, then decremented by 1 each word). The FSM then goes to NOTIFY.
REQ-027 NOTIFY pops no bytes; this is the backpressure point. When master_ready=1, ih_ready pulses on the next cycle.
REQ-028 Exit from NOTIFY: if the command is WRITE and in_data_count>0, go to DATA; otherwise go to IDLE.
REQ-029 in_* outputs are registered and hold their value until overwritten. PING leaves in_address, in_data and in_data_count unchanged.
REQ-030 Minimum latency from the last byte pop to ih_ready is 2 cycles, given master_ready held at 1.
REQ-031 Pulses ih_ready, ih_reset, proto_err and timeout never last more than 1 cycle and are mutually exclusive.
REQ-032 A START_ID byte seen mid-packet is treated as data. There is no resynchronisation except by timeout or reset.

Reset
REQ-033 When rst_n=0, asynchronously:
- state = IDLE.
- All in_* outputs, byte_rd, ih_ready, ih_reset, proto_err, timeout and busy = 0.
- Byte counter and stall counter cleared.
REQ-034 Reset asserted mid-packet discards the partial word. The first byte after release is hunted as in IDLE.

Configuration
REQ-035 Macro HOST_DEFRAMER_TIMEOUT_EN, when defined:
- A stall counter increments each cycle the FSM is in HEADER, ADDRESS or DATA with byte_empty=1.
- The counter clears on every pop and on every state change.
- On reaching TIMEOUT_CYCLES: pulse timeout, clear the partial word, go to IDLE.
- NOTIFY is never timed.
REQ-036 When HOST_DEFRAMER_TIMEOUT_EN is undefined, no stall counter exists, timeout is tied to 0, and the FSM waits indefinitely.

Verification
REQ-037 PING: bytes CD,00,00,00,00 -> one ih_ready pulse; in_command=32'h0.
REQ-038 WRITE, DATA_BYTES=4: bytes 11,22,CD,01,00,00,02, then address 00001000, then data DEADBEEF, 12345678 -> 11 and 22 discarded; two ih_ready pulses:
- first: in_address=32'h1000, in_data=DEADBEEF, in_data_count=1.
- second: in_data=12345678, in_data_count=0.
- busy then drops.
REQ-039 Backpressure: hold master_ready=0 for 50 cycles during the REQ-038 WRITE -> no byte_rd in NOTIFY and no data loss; ih_ready follows master_ready rise by 1 cycle.
REQ-040 Bad command: CD,07,00,00,00 -> proto_err pulse, return to IDLE; a following PING is accepted.
REQ-041 Timeout, macro on, TIMEOUT_CYCLES=16: CD,01 then empty -> timeout pulse 16 cycles after the last pop, then IDLE. Macro off: busy stays high.
REQ-042 Reset mid-packet: drop rst_n after CD,02,00 -> all outputs 0 immediately; next CD,00,00,00,00 -> one ih_ready pulse.
